m1_mem_arbiter: RTL and testbench



---
 rtl/m1_mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_m1_mem_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m1_mem_arbiter.sv
// rtl/m1_mem_arbiter.sv - M1 fetch/data memory port arbiter with watchdog (option macro: M1_ARB_ROUND_ROBIN_EN)
module m1_mem_arbiter #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
   input  logic        sys_clock_i,
   input  logic        sys_reset_i,
   input  logic        imem_read_i,
   input  logic [31:0] imem_addr_i,
   output logic        imem_done_o,
   output logic [31:0] imem_data_o,
   input  logic        dmem_read_i,
   input  logic        dmem_write_i,
   input  logic [3:0]  dmem_sel_i,
   input  logic [31:0] dmem_addr_i,
   input  logic [31:0] dmem_data_i,
   output logic        dmem_done_o,
   output logic [31:0] dmem_data_o,
   output logic        mem_read_o,
   output logic        mem_write_o,
   output logic [3:0]  mem_sel_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic        mem_done_i,
   input  logic [31:0] mem_data_i,
   output logic        abort_o
);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;

   // Watchdog fires in the grant cycle where the count is one short of TIMEOUT,
   // so the strobe stays high for exactly TIMEOUT cycles.
   localparam bit         WDOG_EN = (TIMEOUT != 0);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   state_t     state_nxt;
   logic [7:0] wdog;
   logic       resp_d;
   logic       d_req;
   logic       i_req;
   logic       pick_d;
   logic       timeout_hit;

   assign d_req       = dmem_read_i | dmem_write_i;
   assign i_req       = imem_read_i;
   assign timeout_hit = WDOG_EN && (wdog == TO_LAST);

`ifdef M1_ARB_ROUND_ROBIN_EN
   logic last_d;

   assign pick_d = d_req && (!i_req || !last_d);

   // Remember which port won the most recent grant
   always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
      if (sys_reset_i) begin
         last_d <= 1'b0;
      end else if (state == IDLE && (d_req || i_req)) begin
         last_d <= pick_d;
      end
   end
`else
   // Data port wins contention: a stalled load/store blocks the pipeline
   assign pick_d = d_req;
`endif

   // State register
   always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
      if (sys_reset_i) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state selection
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: begin
            if (d_req || i_req) begin
               state_nxt = pick_d ? GNT_D : GNT_I;
            end
         end
         GNT_I, GNT_D: begin
            if (mem_done_i || timeout_hit) begin
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Completion pulses exist only in RESP, routed to the granted port
   always_comb begin
      imem_done_o = 1'b0;
      dmem_done_o = 1'b0;
      if (state == RESP) begin
         imem_done_o = !resp_d;
         dmem_done_o = resp_d;
      end
   end

   // Memory-side request registers, watchdog and response data capture
   always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
      if (sys_reset_i) begin
         mem_read_o  <= 1'b0;
         mem_write_o <= 1'b0;
         mem_sel_o   <= 4'h0;
         mem_addr_o  <= 32'h0;
         mem_data_o  <= 32'h0;
         imem_data_o <= 32'h0;
         dmem_data_o <= 32'h0;
         abort_o     <= 1'b0;
         wdog        <= 8'h0;
         resp_d      <= 1'b0;
      end else begin
         abort_o <= 1'b0;
         unique case (state)
            IDLE: begin
               wdog <= 8'h0;
               if (d_req || i_req) begin
                  resp_d <= pick_d;
                  if (pick_d) begin
                     mem_read_o  <= dmem_read_i;
                     mem_write_o <= dmem_write_i;
                     mem_sel_o   <= dmem_sel_i;
                     mem_addr_o  <= dmem_addr_i;
                     mem_data_o  <= dmem_data_i;
                  end else begin
                     mem_read_o  <= 1'b1;
                     mem_write_o <= 1'b0;
                     mem_sel_o   <= 4'hF;
                     mem_addr_o  <= imem_addr_i;
                     mem_data_o  <= 32'h0;
                  end
               end
            end
            GNT_I, GNT_D: begin
               wdog <= wdog + 8'd1;
               if (mem_done_i) begin
                  mem_read_o  <= 1'b0;
                  mem_write_o <= 1'b0;
                  if (resp_d) begin
                     dmem_data_o <= mem_write_o ? 32'h0 : mem_data_i;
                  end else begin
                     imem_data_o <= mem_data_i;
                  end
               end else if (timeout_hit) begin
                  mem_read_o  <= 1'b0;
                  mem_write_o <= 1'b0;
                  abort_o     <= 1'b1;
                  if (resp_d) begin
                     dmem_data_o <= ERR_DATA;
                  end else begin
                     imem_data_o <= ERR_DATA;
                  end
               end
            end
            RESP: begin
               wdog <= 8'h0;
            end
            default: begin
               wdog <= 8'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m1_mem_arbiter.sv
// tb/tb_m1_mem_arbiter.sv - scoreboard bench for m1_mem_arbiter (honours M1_ARB_ROUND_ROBIN_EN)
module tb_m1_mem_arbiter;

   localparam int          TO  = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   localparam int          NEVER = 255;

   typedef struct {
      logic        wr;
      logic [3:0]  sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
   } mem_t;

   typedef struct {
      logic        is_d;
      logic [31:0] data;
      logic        abort;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_read_i;
   logic [31:0] imem_addr_i;
   logic        imem_done_o;
   logic [31:0] imem_data_o;
   logic        dmem_read_i;
   logic        dmem_write_i;
   logic [3:0]  dmem_sel_i;
   logic [31:0] dmem_addr_i;
   logic [31:0] dmem_data_i;
   logic        dmem_done_o;
   logic [31:0] dmem_data_o;
   logic        mem_read_o;
   logic        mem_write_o;
   logic [3:0]  mem_sel_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_data_o;
   logic        mem_done_i;
   logic [31:0] mem_data_i;
   logic        abort_o;

   mem_t mem_q[$];
   rsp_t rsp_q[$];
   int   tests = 0;
   int   fails = 0;
   bit   last_d_m = 1'b0;

   m1_mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .sys_clock_i  (clk),
      .sys_reset_i  (rst),
      .imem_read_i  (imem_read_i),
      .imem_addr_i  (imem_addr_i),
      .imem_done_o  (imem_done_o),
      .imem_data_o  (imem_data_o),
      .dmem_read_i  (dmem_read_i),
      .dmem_write_i (dmem_write_i),
      .dmem_sel_i   (dmem_sel_i),
      .dmem_addr_i  (dmem_addr_i),
      .dmem_data_i  (dmem_data_i),
      .dmem_done_o  (dmem_done_o),
      .dmem_data_o  (dmem_data_o),
      .mem_read_o   (mem_read_o),
      .mem_write_o  (mem_write_o),
      .mem_sel_o    (mem_sel_o),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_done_i   (mem_done_i),
      .mem_data_i   (mem_data_i),
      .abort_o      (abort_o)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void push_i(input logic [31:0] a, input logic [31:0] rd, input int lat);
      mem_t m;
      rsp_t r;
      m = '{wr: 1'b0, sel: 4'hF, addr: a, wdata: 32'h0, rdata: rd, lat: lat};
      r = '{is_d: 1'b0, data: (lat > TO) ? ERR : rd, abort: (lat > TO)};
      mem_q.push_back(m);
      rsp_q.push_back(r);
   endfunction

   function automatic void push_d(input logic wr, input logic [3:0] sel, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rd, input int lat);
      mem_t m;
      rsp_t r;
      m = '{wr: wr, sel: sel, addr: a, wdata: wd, rdata: rd, lat: lat};
      r = '{is_d: 1'b1, data: (lat > TO) ? ERR : (wr ? 32'h0 : rd), abort: (lat > TO)};
      mem_q.push_back(m);
      rsp_q.push_back(r);
   endfunction

   // Memory model: returns done after the latency chosen for each request
   initial begin : responder
      mem_t cur;
      int   cnt;
      bit   busy;
      busy = 1'b0;
      cnt = 0;
      cur = '{wr: 1'b0, sel: 4'h0, addr: 32'h0, wdata: 32'h0, rdata: 32'h0, lat: 1};
      mem_done_i = 1'b0;
      mem_data_i = 32'h0;
      forever begin
         @(negedge clk);
         if (mem_read_o || mem_write_o) begin
            if (!busy) begin
               busy = 1'b1;
               cnt = 0;
               if (mem_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_mem_request: addr %h", mem_addr_o);
                  cur.lat = 1;
                  cur.rdata = 32'h0;
               end else begin
                  cur = mem_q.pop_front();
                  chk("mem_write", 32'(mem_write_o), 32'(cur.wr));
                  chk("mem_read", 32'(mem_read_o), 32'(!cur.wr));
                  chk("mem_sel", 32'(mem_sel_o), 32'(cur.sel));
                  chk("mem_addr", mem_addr_o, cur.addr);
                  if (cur.wr) chk("mem_wdata", mem_data_o, cur.wdata);
               end
            end
            cnt++;
            mem_done_i = (cnt == cur.lat);
            mem_data_i = (cnt == cur.lat) ? cur.rdata : $urandom;
         end else begin
            if (busy && cur.lat != NEVER)
               chk("strobe_cycles", 32'(cnt), 32'((cur.lat <= TO) ? cur.lat : TO));
            busy = 1'b0;
            mem_done_i = 1'b0;
         end
      end
   end

   // Response monitor: every done pulse must match the next expected response
   initial begin : monitor
      rsp_t e;
      forever begin
         @(negedge clk);
         if (imem_done_o || dmem_done_o) begin
            if (rsp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: imem %b dmem %b", imem_done_o, dmem_done_o);
            end else begin
               e = rsp_q.pop_front();
               chk("done_port", 32'({dmem_done_o, imem_done_o}), e.is_d ? 32'd2 : 32'd1);
               chk("done_data", e.is_d ? dmem_data_o : imem_data_o, e.data);
               chk("abort", 32'(abort_o), 32'(e.abort));
            end
         end else if (abort_o) begin
            tests++;
            fails++;
            $display("FAIL stray_abort: got 1 expected 0");
         end
      end
   end

   task automatic run_txn(input bit want_i, input bit want_d,
                          input logic [31:0] ia, input logic [31:0] ird, input int ilat,
                          input bit dwr, input logic [3:0] dsel, input logic [31:0] da,
                          input logic [31:0] dwd, input logic [31:0] drd, input int dlat);
      bit d_first;
      bit gi;
      bit gd;
      if (want_i && want_d) begin
`ifdef M1_ARB_ROUND_ROBIN_EN
         d_first = !last_d_m;
         last_d_m = !d_first;
`else
         d_first = 1'b1;
`endif
      end else begin
         d_first = want_d;
         last_d_m = want_d;
      end
      if (d_first) begin
         push_d(dwr, dsel, da, dwd, drd, dlat);
         if (want_i) push_i(ia, ird, ilat);
      end else begin
         if (want_i) push_i(ia, ird, ilat);
         if (want_d) push_d(dwr, dsel, da, dwd, drd, dlat);
      end
      @(negedge clk);
      imem_read_i  = want_i;
      imem_addr_i  = ia;
      dmem_read_i  = want_d && !dwr;
      dmem_write_i = want_d && dwr;
      dmem_sel_i   = dsel;
      dmem_addr_i  = da;
      dmem_data_i  = dwd;
      gi = !want_i;
      gd = !want_d;
      for (int n = 0; n < 300 && !(gi && gd); n++) begin
         @(negedge clk);
         if (imem_done_o) begin
            imem_read_i = 1'b0;
            gi = 1'b1;
         end
         if (dmem_done_o) begin
            dmem_read_i = 1'b0;
            dmem_write_i = 1'b0;
            gd = 1'b1;
         end
      end
      if (!(gi && gd)) begin
         tests++;
         fails++;
         $display("FAIL txn_timeout: imem_done %b dmem_done %b", gi, gd);
         imem_read_i = 1'b0;
         dmem_read_i = 1'b0;
         dmem_write_i = 1'b0;
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_mem_read"}, 32'(mem_read_o), 32'h0);
      chk({tag, "_mem_write"}, 32'(mem_write_o), 32'h0);
      chk({tag, "_mem_sel"}, 32'(mem_sel_o), 32'h0);
      chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
      chk({tag, "_mem_data"}, mem_data_o, 32'h0);
      chk({tag, "_dones"}, 32'({imem_done_o, dmem_done_o, abort_o}), 32'h0);
      chk({tag, "_imem_data"}, imem_data_o, 32'h0);
      chk({tag, "_dmem_data"}, dmem_data_o, 32'h0);
   endtask

   initial begin : driver
      bit   dwr;
      int   kind;
      rst = 1'b1;
      imem_read_i = 1'b0;
      imem_addr_i = 32'h0;
      dmem_read_i = 1'b0;
      dmem_write_i = 1'b0;
      dmem_sel_i = 4'h0;
      dmem_addr_i = 32'h0;
      dmem_data_i = 32'h0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;

      run_txn(1, 0, 32'h100, 32'h1234_5678, 2, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1);
      run_txn(0, 1, 32'h0, 32'h0, 1, 1, 4'b0011, 32'h200, 32'hA5A5_0000, 32'h0, 1);
      for (int k = 0; k < 4; k++)
         run_txn(1, 1, $urandom, $urandom, $urandom_range(1, 3), 0, 4'($urandom),
                 $urandom, $urandom, $urandom, $urandom_range(1, 3));
      run_txn(1, 0, 32'h300, 32'h1111_2222, 100, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1);
      run_txn(0, 1, 32'h0, 32'h0, 1, 0, 4'hC, 32'h340, 32'h0, 32'h3333_4444, TO + 1);
      run_txn(1, 0, 32'h400, 32'hCAFE_F00D, TO, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1);

      // Reset in the middle of a grant: strobes drop immediately, no done pulse
      push_i(32'h500, 32'h0, NEVER);
      void'(rsp_q.pop_back());
      @(negedge clk);
      imem_read_i = 1'b1;
      imem_addr_i = 32'h500;
      for (int n = 0; n < 20 && !mem_read_o; n++) @(negedge clk);
      chk("rst_test_strobe_seen", 32'(mem_read_o), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      imem_read_i = 1'b0;
      #1;
      check_zero("midrst");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      last_d_m = 1'b0;
      run_txn(1, 0, 32'h600, 32'h0BAD_F00D, 1, 0, 4'h0, 32'h0, 32'h0, 32'h0, 1);

      for (int k = 0; k < 150; k++) begin
         kind = $urandom_range(0, 2);
         dwr  = 1'($urandom_range(0, 1));
         run_txn(kind != 1, kind != 0, $urandom, $urandom, $urandom_range(1, TO + 2),
                 dwr, 4'($urandom), $urandom, $urandom, $urandom,
                 dwr ? $urandom_range(1, TO) : $urandom_range(1, TO + 2));
      end

      repeat (5) @(negedge clk);
      chk("rsp_q_empty", 32'(rsp_q.size()), 32'h0);
      chk("mem_q_empty", 32'(mem_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
